bus_arbiter: RTL and testbench

- Shares one external memory bus between the fetch unit (word reads) and the memory stage (byte/half/word loads and stores).
- Serialises accesses and performs byte-lane steering for stores and extraction/extension for loads.
- Drives per-requester stall lines to the hazard unit.
- Sits between fetch/memory stage and the core's bus interface pins.

---
 rtl/bus_arbiter_pkg.sv | 60 ++++++
 rtl/bus_arbiter_lane_align.sv | 28 ++
 rtl/bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and lane helpers for the bus arbiter slice.
// State encoding, access size codes, store lane steering and load extraction.
package bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_F,
        BUSY_D,
        DONE_F,
        DONE_D
    } arb_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic [3:0]  strobe;
        logic [31:0] data;
    } store_lanes_t;

    // Byte enables and replicated store data; size 11 falls through to word.
    function automatic store_lanes_t steer_store(input logic [1:0]  size,
                                                 input logic [1:0]  offset,
                                                 input logic [31:0] data);
        store_lanes_t r;
        case (size)
            SIZE_BYTE: begin
                r.strobe = 4'b0001 << offset;
                r.data   = {4{data[7:0]}};
            end
            SIZE_HALF: begin
                r.strobe = 4'b0011 << offset;
                r.data   = {2{data[15:0]}};
            end
            default: begin
                r.strobe = 4'b1111;
                r.data   = data;
            end
        endcase
        return r;
    endfunction

    // Shift the addressed bytes down, then zero- or sign-extend to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  offset,
                                                 input logic        sign_ext);
        logic [31:0] shifted;
        logic [31:0] r;
        shifted = word >> {offset, 3'b000};
        case (size)
            SIZE_BYTE: r = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: r = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default:   r = shifted;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bus_arbiter_lane_align.sv
// bus_lane_align: combinational store steering and load extraction.
// Kept separate so a future cache front end can reuse the same lane logic.
module bus_lane_align
    import bus_arbiter_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    output logic [3:0]  st_strobe,
    output logic [31:0] st_wdata,
    input  logic [31:0] ld_word,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_offset,
    input  logic        ld_signed,
    output logic [31:0] ld_data
);

    store_lanes_t lanes;

    // Store side works on the live request, load side on the latched attributes.
    always_comb begin
        lanes     = steer_store(st_size, st_offset, st_data);
        st_strobe = lanes.strobe;
        st_wdata  = lanes.data;
        ld_data   = extract_load(ld_word, ld_size, ld_offset, ld_signed);
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: serialises fetch and memory-stage accesses onto one bus.
// Optional bus timeout is compiled in with `define BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int          DATA_PRIORITY  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        fetch_read,
    input  logic [31:0] fetch_address,
    output logic [31:0] fetch_data,
    output logic        fetch_stall,
    output logic        fetch_error,
    input  logic        mem_load,
    input  logic        mem_store,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_store_data,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    output logic [31:0] mem_load_data,
    output logic        data_stall,
    output logic        data_error,
    output logic [31:0] ext_address,
    output logic [31:0] ext_write_data,
    output logic [3:0]  ext_strobe,
    output logic        ext_read,
    output logic        ext_write,
    input  logic        ext_ready,
    input  logic [31:0] ext_read_data
);

    arb_state_t  state_q, state_d;
    logic        data_req, issue_f, issue_d, busy, complete, timeout_hit;
    logic [31:0] fetch_addr_q;
    logic [1:0]  lat_size, lat_off;
    logic        lat_signed, lat_store;
    logic [3:0]  st_strobe;
    logic [31:0] st_wdata, ld_data;

    assign data_req = mem_load | mem_store;
    assign busy     = (state_q == BUSY_F) || (state_q == BUSY_D);
    assign complete = busy && (ext_ready || timeout_hit);

    assign data_stall  = data_req && (state_q != DONE_D);
    assign fetch_stall = fetch_read &&
                         !((state_q == DONE_F) && (fetch_address == fetch_addr_q));

    bus_lane_align u_align (
        .st_size   (mem_size),
        .st_offset (mem_address[1:0]),
        .st_data   (mem_store_data),
        .st_strobe (st_strobe),
        .st_wdata  (st_wdata),
        .ld_word   (ext_read_data),
        .ld_size   (lat_size),
        .ld_offset (lat_off),
        .ld_signed (lat_signed),
        .ld_data   (ld_data)
    );

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        tmo_flag;

    // ext_ready in the final allowed cycle still counts as a normal completion.
    assign timeout_hit = busy && !ext_ready && (tmo_cnt == TIMEOUT_CYCLES - 1);
    assign fetch_error = tmo_flag && (state_q == DONE_F);
    assign data_error  = tmo_flag && (state_q == DONE_D);

    // Wait counter runs only while a transaction is outstanding.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            tmo_cnt  <= (busy && !complete) ? tmo_cnt + 32'd1 : '0;
            tmo_flag <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign fetch_error = 1'b0;
    assign data_error  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Arbitration and next-state selection.
    always_comb begin
        state_d = state_q;
        issue_f = 1'b0;
        issue_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_req && (DATA_PRIORITY != 0 || !fetch_read)) begin
                    issue_d = 1'b1;
                    state_d = BUSY_D;
                end else if (fetch_read) begin
                    issue_f = 1'b1;
                    state_d = BUSY_F;
                end
            end
            BUSY_F:  if (complete) state_d = DONE_F;
            BUSY_D:  if (complete) state_d = DONE_D;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs, request attributes and result registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ext_address    <= '0;
            ext_write_data <= '0;
            ext_strobe     <= '0;
            ext_read       <= 1'b0;
            ext_write      <= 1'b0;
            fetch_addr_q   <= '0;
            lat_size       <= '0;
            lat_off        <= '0;
            lat_signed     <= 1'b0;
            lat_store      <= 1'b0;
            fetch_data     <= '0;
            mem_load_data  <= '0;
        end else begin
            if (issue_d) begin
                ext_address <= {mem_address[31:2], 2'b00};
                ext_read    <= !mem_store;
                ext_write   <= mem_store;
                ext_strobe  <= mem_store ? st_strobe : 4'b1111;
                if (mem_store) ext_write_data <= st_wdata;
                lat_size    <= mem_size;
                lat_off     <= mem_address[1:0];
                lat_signed  <= mem_signed;
                lat_store   <= mem_store;
            end
            if (issue_f) begin
                ext_address  <= {fetch_address[31:2], 2'b00};
                ext_read     <= 1'b1;
                ext_write    <= 1'b0;
                ext_strobe   <= 4'b1111;
                fetch_addr_q <= fetch_address;
            end
            if (complete) begin
                ext_read   <= 1'b0;
                ext_write  <= 1'b0;
                ext_strobe <= '0;
                if (state_q == BUSY_F)
                    fetch_data <= timeout_hit ? '0 : ext_read_data;
                else if (!lat_store)
                    mem_load_data <= timeout_hit ? '0 : ld_data;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed spec cases plus random traffic
// against a byte-lane reference model. Timeout cases need BUS_ARBITER_TIMEOUT_EN.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        fetch_read;
    logic [31:0] fetch_address;
    logic [31:0] fetch_data;
    logic        fetch_stall, fetch_error;
    logic        mem_load, mem_store;
    logic [31:0] mem_address, mem_store_data;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic [31:0] mem_load_data;
    logic        data_stall, data_error;
    logic [31:0] ext_address, ext_write_data;
    logic [3:0]  ext_strobe;
    logic        ext_read, ext_write, ext_ready;
    logic [31:0] ext_read_data;

    int checks   = 0;
    int failures = 0;

    bus_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .resetn(resetn),
        .fetch_read(fetch_read), .fetch_address(fetch_address),
        .fetch_data(fetch_data), .fetch_stall(fetch_stall), .fetch_error(fetch_error),
        .mem_load(mem_load), .mem_store(mem_store), .mem_address(mem_address),
        .mem_store_data(mem_store_data), .mem_size(mem_size), .mem_signed(mem_signed),
        .mem_load_data(mem_load_data), .data_stall(data_stall), .data_error(data_error),
        .ext_address(ext_address), .ext_write_data(ext_write_data),
        .ext_strobe(ext_strobe), .ext_read(ext_read), .ext_write(ext_write),
        .ext_ready(ext_ready), .ext_read_data(ext_read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access width in bytes; size 11 behaves as a word.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_strobe(input bit st, input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] r;
        int n, off;
        n   = nbytes(sz);
        off = (n == 4) ? 0 : int'(a);
        for (int i = 0; i < 4; i++) r[i] = !st || (i >= off && i < off + n);
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = nbytes(sz);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [1:0] sz,
                                           input logic [1:0] a, input bit sg);
        longint v, lim;
        int nb;
        nb  = 8 * nbytes(sz);
        lim = longint'(1) << nb;
        v   = longint'(word >> (8 * int'(a))) % lim;
        if (sg && v >= lim / 2) v = v - lim;
        return 32'(v);
    endfunction

    // One transaction with a simple bus responder: ext_ready comes dly cycles
    // after the strobe appears. Read data is rd only for the current address.
    task automatic txn(input bit is_f, input bit st, input logic [31:0] addr,
                       input logic [1:0] sz, input bit sg, input logic [31:0] wd,
                       input logic [31:0] rd, input int dly,
                       input bit redir, input logic [31:0] raddr);
        int scnt, nbus, stalls;
        bit done, stall;
        logic [31:0] cur;
        if (is_f) begin
            fetch_read = 1'b1; fetch_address = addr;
        end else begin
            mem_load = !st; mem_store = st; mem_address = addr;
            mem_size = sz; mem_signed = sg; mem_store_data = wd;
        end
        ext_ready = 1'b0;
        scnt = 0; nbus = 0; stalls = 0; done = 0; cur = addr;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            stall = is_f ? fetch_stall : data_stall;
            if (!stall) done = 1;
            else begin
                stalls++;
                @(posedge clk); #1;
                if (ext_read || ext_write) begin
                    if (scnt == 0) begin
                        nbus++;
                        check("bus_addr", ext_address, {cur[31:2], 2'b00});
                        check("bus_read", 32'(ext_read), 32'(is_f || !st));
                        check("bus_write", 32'(ext_write), 32'(!is_f && st));
                        check("bus_strobe", 32'(ext_strobe), 32'(m_strobe(st && !is_f, sz, cur[1:0])));
                        if (!is_f && st) check("bus_wdata", ext_write_data, m_wdata(sz, wd));
                        if (redir && nbus == 1) begin
                            fetch_address = raddr; cur = raddr;
                        end
                    end
                    scnt++;
                    ext_read_data = (ext_address == {cur[31:2], 2'b00}) ? rd : ~rd;
                    ext_ready = (scnt == dly + 1);
                end else begin
                    scnt = 0; ext_ready = 1'b0;
                end
            end
        end
        check("txn_done", 32'(done), 32'd1);
        if (done) begin
            if (is_f) check("fetch_data", fetch_data, rd);
            else if (!st) check("load_data", mem_load_data, m_load(rd, sz, cur[1:0], sg));
            check("stall_cycles", 32'(stalls), redir ? 32'(2 * dly + 5) : 32'(dly + 2));
            if (redir) check("redir_bus_count", 32'(nbus), 32'd2);
            check("err_flags", {30'd0, fetch_error, data_error}, 32'd0);
        end
        @(posedge clk); #1;
        fetch_read = 1'b0; mem_load = 1'b0; mem_store = 1'b0; ext_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] a, w;
        logic [1:0]  sz;
        int kind, tcnt;
        bit found;

        resetn = 1'b0; fetch_read = 1'b0; fetch_address = '0;
        mem_load = 1'b0; mem_store = 1'b0; mem_address = '0; mem_store_data = '0;
        mem_size = '0; mem_signed = 1'b0; ext_ready = 1'b0; ext_read_data = '0;
        repeat (2) @(negedge clk);
        check("rst_ext", {ext_address | ext_write_data}, 32'd0);
        check("rst_ctl", {27'd0, ext_strobe, ext_read, ext_write}, 32'd0);
        check("rst_results", fetch_data | mem_load_data, 32'd0);
        check("rst_err", {30'd0, fetch_error, data_error}, 32'd0);
        @(posedge clk); #1; resetn = 1'b1;
        @(posedge clk); #1;

        // Fetch only, ready in the first strobe cycle.
        txn(1, 0, 32'h100, 2'b10, 0, '0, 32'hDEAD_BEEF, 0, 0, '0);

        // Simultaneous fetch and load: data wins, fetch follows after DONE_D.
        fetch_read = 1'b1; fetch_address = 32'h200;
        mem_load = 1'b1; mem_address = 32'h300; mem_size = 2'b10; mem_signed = 1'b0;
        @(posedge clk); #1;
        check("prio_addr", ext_address, 32'h300);
        check("prio_read", 32'(ext_read), 32'd1);
        ext_ready = 1'b1; ext_read_data = 32'h1357_9BDF;
        @(posedge clk); #1; ext_ready = 1'b0;
        @(negedge clk);
        check("prio_dstall", 32'(data_stall), 32'd0);
        check("prio_fstall", 32'(fetch_stall), 32'd1);
        check("prio_ldata", mem_load_data, 32'h1357_9BDF);
        @(posedge clk); #1; mem_load = 1'b0;
        found = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            if (ext_read) found = 1;
            else begin @(posedge clk); #1; end
        end
        check("prio_fetch_issued", 32'(found), 32'd1);
        check("prio_fetch_addr", ext_address, 32'h200);
        ext_ready = 1'b1; ext_read_data = 32'h2468_ACE0;
        @(posedge clk); #1; ext_ready = 1'b0;
        @(negedge clk);
        check("prio_fetch_stall", 32'(fetch_stall), 32'd0);
        check("prio_fetch_data", fetch_data, 32'h2468_ACE0);
        @(posedge clk); #1; fetch_read = 1'b0;

        // Load extraction and half-store steering examples.
        txn(0, 0, 32'h1003, 2'b00, 1, '0, 32'h80FF_1234, 1, 0, '0);
        check("sbyte_exact", mem_load_data, 32'hFFFF_FF80);
        txn(0, 0, 32'h1002, 2'b01, 0, '0, 32'h80FF_1234, 0, 0, '0);
        check("uhalf_exact", mem_load_data, 32'h0000_80FF);
        txn(0, 1, 32'h2002, 2'b01, 0, 32'h0000_ABCD, '0, 0, 0, '0);
        // Size 11 behaves as a word for both directions.
        txn(0, 1, 32'h2100, 2'b11, 0, 32'hCAFE_F00D, '0, 2, 0, '0);
        txn(0, 0, 32'h2104, 2'b11, 1, '0, 32'h8000_0001, 0, 0, '0);

        // Fetch redirected while busy: first result discarded, re-read at new address.
        txn(1, 0, 32'h100, 2'b10, 0, '0, 32'h0BAD_CAFE, 2, 1, 32'h400);

`ifdef BUS_ARBITER_TIMEOUT_EN
        mem_load = 1'b1; mem_address = 32'h40; mem_size = 2'b10; ext_ready = 1'b0;
        tcnt = 0; found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (ext_read) tcnt++;
            if (!data_stall) found = 1;
        end
        check("tmo_done", 32'(found), 32'd1);
        check("tmo_strobe_cycles", 32'(tcnt), 32'd8);
        check("tmo_data_error", 32'(data_error), 32'd1);
        check("tmo_load_zero", mem_load_data, 32'd0);
        check("tmo_strobe_low", 32'(ext_read), 32'd0);
        @(posedge clk); #1; mem_load = 1'b0;
        @(negedge clk);
        check("tmo_error_pulse", 32'(data_error), 32'd0);
`else
        // Without the timeout the arbiter simply waits.
        txn(0, 0, 32'h44, 2'b10, 0, '0, 32'h1111_2222, 20, 0, '0);
`endif

        // Random traffic.
        for (int k = 0; k < 24; k++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            sz = 2'($urandom_range(0, 3));
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz[1]) a[1:0] = 2'b00;
            w = $urandom;
            if (kind == 0) begin
                a[1:0] = 2'b00;
                txn(1, 0, a, 2'b10, 0, '0, w, $urandom_range(0, 3), 0, '0);
            end else begin
                txn(0, kind == 2, a, sz, 1'($urandom), $urandom, w, $urandom_range(0, 3), 0, '0);
            end
        end

        // Reset during BUSY drops the strobes without waiting for a clock edge.
        mem_load = 1'b1; mem_address = 32'h80; mem_size = 2'b10;
        @(posedge clk); #1;
        check("mid_busy_read", 32'(ext_read), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_read", 32'(ext_read), 32'd0);
        check("async_rst_strobe", 32'(ext_strobe), 32'd0);
        mem_load = 1'b0;
        @(posedge clk); #1; resetn = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(ext_read | ext_write), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
